// File: rtl/ifu_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package ifu_pkg;

   localparam int INST_W   = 32;
   localparam int MAX_XLEN = 64;
   // Width of the outstanding-request counters. Stale requests from earlier
   // redirects stay outstanding while new ones are issued, so this is wider
   // than the buffer count.
   localparam int PEND_W   = 16;

   localparam logic [INST_W-1:0] NOP_INST         = 32'h00000013;
   localparam logic [31:0]       RESET_PC_DEFAULT = 32'h80000000;

   // Instruction addresses are word aligned: clear the two low bits.
   function automatic logic [MAX_XLEN-1:0] align_pc(input logic [MAX_XLEN-1:0] pc);
      return {pc[MAX_XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifu_entry_buf.sv
// In-order fetch buffer: entries are allocated when a request is accepted,
// filled when its response returns, and popped when the decoder takes them.
// Pointers wrap naturally; full/empty is decided by count alone.
module ifu_entry_buf
   import ifu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              alloc_en,
   input  logic [XLEN-1:0]   alloc_pc,
   input  logic              fill_en,
   input  logic [INST_W-1:0] fill_inst,
   input  logic              pop_en,
   output logic [PW:0]       count,
   output logic              head_valid,
   output logic [XLEN-1:0]   head_pc,
   output logic [INST_W-1:0] head_inst
);

   logic [PW-1:0]     alloc_ptr;
   logic [PW-1:0]     fill_ptr;
   logic [PW-1:0]     pop_ptr;
   logic [DEPTH-1:0]  filled;
   logic [XLEN-1:0]   pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];

   // Pointer, count and filled-bit bookkeeping; a flush empties the buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         pop_ptr   <= '0;
         count     <= '0;
         filled    <= '0;
      end else if (flush) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         pop_ptr   <= '0;
         count     <= '0;
         filled    <= '0;
      end else begin
         if (alloc_en) begin
            alloc_ptr         <= alloc_ptr + 1'b1;
            filled[alloc_ptr] <= 1'b0;
         end
         if (fill_en) begin
            fill_ptr         <= fill_ptr + 1'b1;
            filled[fill_ptr] <= 1'b1;
         end
         if (pop_en) begin
            pop_ptr <= pop_ptr + 1'b1;
         end
         case ({alloc_en, pop_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry payload storage; contents of free entries are don't-care.
   always_ff @(posedge clk) begin
      if (alloc_en) begin
         pc_mem[alloc_ptr] <= alloc_pc;
      end
      if (fill_en) begin
         inst_mem[fill_ptr] <= fill_inst;
      end
   end

   assign head_valid = (count != '0) && filled[pop_ptr];
   assign head_pc    = pc_mem[pop_ptr];
   assign head_inst  = inst_mem[pop_ptr];

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests to
// instruction memory, buffers up to DEPTH fetches and hands {pc, inst} to the
// decoder. A redirect flushes the buffer and marks outstanding responses stale.
// Optional build macro IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_drop_cnt.
//
// Handshakes: a transfer happens on a cycle where valid && ready at the clock
// edge. Once raised, valid and its payload hold until ready, except that a
// redirect may withdraw a fetch request. Memory responses have no ready: they
// return in request order and are always accepted.
module ifu_prefetch
   import ifu_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
   parameter int              DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_inst,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   input  logic              redirect_en,
   input  logic [XLEN-1:0]   redirect_pc
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_drop_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0]   fetch_pc;
   logic [PEND_W-1:0] pending;
   logic [PEND_W-1:0] discard;
   logic [CW-1:0]     count;
   logic              head_valid;
   logic [INST_W-1:0] head_inst;
   logic              req_fire;
   logic              resp_take;
   logic              resp_drop;
   logic              fill_en;
   logic              pop_en;

   assign imem_req_valid = !rst && (count < CW'(DEPTH)) && !redirect_en;
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is ignored entirely.
   assign resp_take = imem_resp_valid && (pending != '0);
   assign resp_drop = resp_take && (redirect_en || (discard != '0));
   assign fill_en   = resp_take && !resp_drop;

   assign out_valid = head_valid;
   assign out_inst  = head_valid ? head_inst : NOP_INST;
   assign pop_en    = head_valid && out_ready && !redirect_en;

   ifu_entry_buf #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_en),
      .alloc_en   (req_fire),
      .alloc_pc   (fetch_pc),
      .fill_en    (fill_en),
      .fill_inst  (imem_resp_inst),
      .pop_en     (pop_en),
      .count      (count),
      .head_valid (head_valid),
      .head_pc    (out_pc),
      .head_inst  (head_inst)
   );

   // Fetch PC: restart at the aligned target on redirect, else step per request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
      end else if (redirect_en) begin
         fetch_pc <= XLEN'(align_pc(MAX_XLEN'(redirect_pc)));
      end else if (req_fire) begin
         fetch_pc <= fetch_pc + XLEN'(4);
      end
   end

   // Outstanding and stale-response counters. On redirect every request still
   // outstanding after this cycle becomes stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         discard <= '0;
      end else begin
         assert (!(imem_resp_valid && (pending == '0)));
         if (redirect_en) begin
            pending <= pending - PEND_W'(resp_take);
            discard <= pending - PEND_W'(resp_take);
         end else begin
            pending <= pending + PEND_W'(req_fire) - PEND_W'(resp_take);
            if (resp_drop) begin
               discard <= discard - 1'b1;
            end
         end
      end
   end

`ifdef IFU_PERF_CNT_EN
   // Delivered-instruction and dropped-response event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetch_cnt <= '0;
         perf_drop_cnt  <= '0;
      end else begin
         if (pop_en) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
         if (resp_drop) begin
            perf_drop_cnt <= perf_drop_cnt + 32'd1;
         end
      end
   end
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: in-order memory model with variable latency, and a
// reference model that tracks the stream of fetched PCs since the last
// redirect, which entries have their data back, and stale responses.
module tb_ifu_prefetch;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h80000000;
   localparam logic [31:0] NOP    = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_inst = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        redirect_en = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef IFU_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_drop_cnt;
`endif

   ifu_prefetch #(.XLEN(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_inst  (imem_resp_inst),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst),
      .redirect_en     (redirect_en),
      .redirect_pc     (redirect_pc)
`ifdef IFU_PERF_CNT_EN
      ,
      .perf_fetch_cnt  (perf_fetch_cnt),
      .perf_drop_cnt   (perf_drop_cnt)
`endif
   );

   // Clock
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } mreq_t;

   mreq_t       mq[$];      // requests accepted by memory, not yet answered
   logic [31:0] exp_q[$];   // PCs the decoder should still receive, in order
   int          n_ready;    // leading entries of exp_q whose data is back
   int          epoch;
   int          cyc;
   int          lat = 1;
   int          m_pops;
   int          m_drops;
   int          n_acc;
   logic [31:0] model_pc;
   bit          last_pop;
   int          n_checks = 0;
   int          n_fail = 0;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h0F0F1357;
   endfunction

   // Memory response driver: answers the oldest request once its latency expires.
   task automatic drive_mem();
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_inst  = inst_of(mq[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_inst  = $urandom;
      end
   endtask

   task automatic model_clear();
      mq.delete();
      exp_q.delete();
      n_ready  = 0;
      epoch    = 0;
      cyc      = 0;
      m_pops   = 0;
      m_drops  = 0;
      model_pc = RST_PC;
   endtask

   // One clock: sample and score outputs, advance the model, step the clock.
   // Called just after a falling edge with inputs already driven.
   task automatic cycle();
      bit    exp_rv;
      bit    exp_ov;
      mreq_t h;
      mreq_t n;
      #1;
      last_pop = 1'b0;
      exp_rv = (exp_q.size() < DEPTH) && !redirect_en;
      exp_ov = (n_ready > 0);
      n_checks++;
      if (imem_req_valid !== exp_rv) begin
         n_fail++;
         $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
      end
      if (exp_rv) begin
         n_checks++;
         if (imem_req_addr !== model_pc) begin
            n_fail++;
            $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, model_pc);
         end
      end
      n_checks++;
      if (out_valid !== exp_ov) begin
         n_fail++;
         $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_ov);
      end
      if (exp_ov) begin
         n_checks++;
         if (out_pc !== exp_q[0] || out_inst !== inst_of(exp_q[0])) begin
            n_fail++;
            $display("FAIL out_data cyc=%0d got=%h/%h exp=%h/%h", cyc, out_pc, out_inst,
                     exp_q[0], inst_of(exp_q[0]));
         end
      end else begin
         n_checks++;
         if (out_inst !== NOP) begin
            n_fail++;
            $display("FAIL out_nop cyc=%0d got=%h exp=%h", cyc, out_inst, NOP);
         end
      end
`ifdef IFU_PERF_CNT_EN
      n_checks++;
      if (perf_fetch_cnt !== 32'(m_pops) || perf_drop_cnt !== 32'(m_drops)) begin
         n_fail++;
         $display("FAIL perf_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, perf_fetch_cnt,
                  perf_drop_cnt, m_pops, m_drops);
      end
`endif
      // Reference model update for this clock edge.
      if (imem_resp_valid) begin
         h = mq.pop_front();
         if (redirect_en || h.epoch != epoch) m_drops++;
         else n_ready++;
      end
      if (redirect_en) begin
         exp_q.delete();
         n_ready  = 0;
         epoch++;
         model_pc = {redirect_pc[31:2], 2'b00};
      end else begin
         if (exp_ov && out_ready) begin
            void'(exp_q.pop_front());
            n_ready--;
            m_pops++;
            last_pop = 1'b1;
         end
         if (exp_rv && imem_req_ready) begin
            exp_q.push_back(model_pc);
            n.addr  = model_pc;
            n.epoch = epoch;
            n.due   = cyc + lat;
            mq.push_back(n);
            model_pc = model_pc + 32'd4;
            n_acc++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      drive_mem();
   endtask

   // Asynchronous reset, possibly in the middle of traffic.
   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b0 || out_valid !== 1'b0 || out_inst !== NOP) begin
         n_fail++;
         $display("FAIL reset_async got=%b/%b/%h exp=0/0/%h", imem_req_valid, out_valid, out_inst, NOP);
      end
      imem_req_ready = 1'b0;
      out_ready      = 1'b0;
      redirect_en    = 1'b0;
      model_clear();
      drive_mem();
      repeat (2) @(negedge clk);
      n_checks++;
      if (imem_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold req_valid got=%b exp=0", imem_req_valid);
      end
`ifdef IFU_PERF_CNT_EN
      n_checks++;
      if (perf_fetch_cnt !== 32'd0 || perf_drop_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_fetch_cnt, perf_drop_cnt);
      end
`endif
      rst = 1'b0;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
         n_fail++;
         $display("FAIL reset_release got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RST_PC);
      end
   endtask

   // 1-cycle memory, everything ready: one instruction per cycle once primed.
   task automatic test_stream();
      int pops = 0;
      int acc0 = n_acc;
      lat = 1;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (last_pop) pops++;
      end
      n_checks++;
      if (pops != 18 || n_acc - acc0 != 20) begin
         n_fail++;
         $display("FAIL stream_rate got pops=%0d reqs=%0d exp pops=18 reqs=20", pops, n_acc - acc0);
      end
   endtask

   // Decoder stalled: buffer fills to DEPTH, then requests stop and resume later.
   task automatic test_full();
      int acc0;
      int pops = 0;
      test_reset();
      lat = 1;
      imem_req_ready = 1'b1;
      out_ready      = 1'b0;
      acc0 = n_acc;
      repeat (8) cycle();
      n_checks++;
      if (n_acc - acc0 != DEPTH || imem_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL full_stop got reqs=%0d valid=%b exp reqs=%0d valid=0", n_acc - acc0,
                  imem_req_valid, DEPTH);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (last_pop) pops++;
      end
      n_checks++;
      if (n_acc - acc0 <= DEPTH || pops < DEPTH) begin
         n_fail++;
         $display("FAIL full_resume got reqs=%0d pops=%0d exp reqs>%0d pops>=%0d", n_acc - acc0,
                  pops, DEPTH, DEPTH);
      end
   endtask

   // Memory not ready: request address holds and the fetch PC does not advance.
   task automatic test_stall();
      test_reset();
      lat = 1;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      cycle();
      cycle();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000008) begin
            n_fail++;
            $display("FAIL stall_hold got=%b/%h exp=1/80000008", imem_req_valid, imem_req_addr);
         end
         cycle();
      end
      imem_req_ready = 1'b1;
      cycle();
      #1;
      n_checks++;
      if (imem_req_addr !== 32'h8000000C) begin
         n_fail++;
         $display("FAIL stall_advance got=%h exp=8000000c", imem_req_addr);
      end
   endtask

   // Two requests in flight at latency 3, then redirect: both responses dropped.
   task automatic test_redirect_drop();
      int n = 0;
      test_reset();
      lat = 3;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      cycle();
      cycle();
      imem_req_ready = 1'b0;
      redirect_en    = 1'b1;
      redirect_pc    = 32'h80000100;
      cycle();
      redirect_en    = 1'b0;
      imem_req_ready = 1'b1;
      lat = 1;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000100) begin
         n_fail++;
         $display("FAIL redir_first_req got=%b/%h exp=1/80000100", imem_req_valid, imem_req_addr);
      end
      out_ready = 1'b0;
      while (!out_valid && n < 20) begin
         cycle();
         n++;
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h80000100 || out_inst !== inst_of(32'h80000100)) begin
         n_fail++;
         $display("FAIL redir_out got=%b/%h/%h exp=1/80000100/%h", out_valid, out_pc, out_inst,
                  inst_of(32'h80000100));
      end
`ifdef IFU_PERF_CNT_EN
      n_checks++;
      if (perf_drop_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL redir_drop_cnt got=%0d exp=2", perf_drop_cnt);
      end
`endif
      out_ready = 1'b1;
      repeat (6) cycle();
   endtask

   // Redirect in the same cycle as a response while the decoder is ready.
   task automatic test_redirect_resp();
      int n = 0;
      int pops0;
      test_reset();
      lat = 2;
      imem_req_ready = 1'b1;
      out_ready      = 1'b0;
      while (!(imem_resp_valid && out_valid) && n < 20) begin
         cycle();
         n++;
      end
      n_checks++;
      if (!(imem_resp_valid && out_valid)) begin
         n_fail++;
         $display("FAIL redir_resp_setup got out_valid=%b exp=1", out_valid);
      end
      pops0 = m_pops;
      redirect_en = 1'b1;
      redirect_pc = 32'h80000040;
      out_ready   = 1'b1;
      cycle();
      redirect_en = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80000040) begin
         n_fail++;
         $display("FAIL redir_resp got=%b/%b/%h exp=0/1/80000040", out_valid, imem_req_valid,
                  imem_req_addr);
      end
`ifdef IFU_PERF_CNT_EN
      n_checks++;
      if (perf_fetch_cnt !== 32'(pops0) || perf_drop_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL redir_resp_perf got=%0d/%0d exp=%0d/1", perf_fetch_cnt, perf_drop_cnt, pops0);
      end
`endif
      repeat (8) cycle();
   endtask

   // Target alignment, back-to-back redirects, and PC wrap at the top of memory.
   task automatic test_align_wrap();
      lat = 1;
      imem_req_ready = 1'b1;
      out_ready      = 1'b1;
      redirect_en    = 1'b1;
      redirect_pc    = 32'h80000203;
      cycle();
      redirect_en = 1'b0;
      #1;
      n_checks++;
      if (imem_req_addr !== 32'h80000200) begin
         n_fail++;
         $display("FAIL align got=%h exp=80000200", imem_req_addr);
      end
      redirect_en = 1'b1;
      redirect_pc = 32'h11111110;
      cycle();
      redirect_pc = 32'hFFFFFFF6;
      cycle();
      redirect_en = 1'b0;
      #1;
      n_checks++;
      if (imem_req_addr !== 32'hFFFFFFF4) begin
         n_fail++;
         $display("FAIL last_redirect got=%h exp=fffffff4", imem_req_addr);
      end
      repeat (3) cycle();
      #1;
      n_checks++;
      if (imem_req_addr !== 32'h00000000) begin
         n_fail++;
         $display("FAIL pc_wrap got=%h exp=00000000", imem_req_addr);
      end
      repeat (6) cycle();
   endtask

   // Random handshakes, latencies and redirects against the model.
   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         lat            = $urandom_range(1, 4);
         imem_req_ready = ($urandom_range(0, 3) != 0);
         out_ready      = ($urandom_range(0, 2) != 0);
         redirect_en    = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
         else redirect_pc = $urandom;
         cycle();
      end
      redirect_en    = 1'b0;
      imem_req_ready = 1'b1;
      out_ready      = 1'b0;
      lat            = 1;
      repeat (6) cycle();
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      model_clear();
      n_acc = 0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_full();
      test_stall();
      test_redirect_drop();
      test_redirect_resp();
      test_align_wrap();
      test_random();
      test_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
